// File: rtl/operand_entry_sequencer.sv
// operand_entry_sequencer: synchronizes and debounces the KEY push-button, then
// captures two switch operands in sequence (A, then B) for the adder datapath.
// Optional feature macro: OPSEQ_TIMEOUT_EN (abandon entry after TIMEOUT_CYCLES
// in WAIT_B without a press).
module operand_entry_sequencer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             key_n,
  input  logic [WIDTH-1:0] sw_data,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             operands_valid,
  output logic [1:0]       state,
  output logic             press_pulse
);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    SHOW   = 2'b10,
    BAD    = 2'b11
  } state_e;

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

  // Reject parameter values the counters cannot represent.
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;
  logic [DCW-1:0]   db_cnt_q, db_cnt_d;
  logic             press_q, press_d;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             valid_q, valid_d;
  logic             timeout;

  // Synchronizer, debounce counter and falling-edge detect on the stable level.
  always_comb begin
    sync_d       = {sync_q[0], key_n};
    stable_d     = stable_q;
    db_cnt_d     = '0;
    if (sync_q[1] != stable_q) begin
      if (db_cnt_q == DB_LAST) stable_d = ~stable_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
    stable_dly_d = stable_q;
    // Only a released->pressed transition produces a strobe.
    press_d      = stable_dly_q & ~stable_q;
  end

`ifdef OPSEQ_TIMEOUT_EN
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  assign timeout = (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1));

  // Timeout counter: runs only while WAIT_B sits without a press.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == WAIT_B) begin
      if (press_q || timeout) to_cnt_d = '0;
      else                    to_cnt_d = to_cnt_q + 1'b1;
    end else if (state_d == WAIT_B) begin
      to_cnt_d = '0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Entry FSM: next state and operand captures, driven by the press strobe.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    valid_d = valid_q;
    case (state_q)
      WAIT_A: if (press_q) begin
        op_a_d  = sw_data;
        state_d = WAIT_B;
      end
      WAIT_B: if (press_q) begin
        op_b_d  = sw_data;
        valid_d = 1'b1;
        state_d = SHOW;
      end else if (timeout) begin
        op_a_d  = '0;
        state_d = WAIT_A;
      end
      SHOW: if (press_q) begin
        // This press is the A of a fresh entry.
        op_a_d  = sw_data;
        op_b_d  = '0;
        valid_d = 1'b0;
        state_d = WAIT_B;
      end
      default: begin
        valid_d = 1'b0;
        state_d = WAIT_A;
      end
    endcase
  end

  // All registers; reset overrides any pending press.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync_q       <= 2'b11;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      db_cnt_q     <= '0;
      press_q      <= 1'b0;
      state_q      <= WAIT_A;
      op_a_q       <= '0;
      op_b_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      db_cnt_q     <= db_cnt_d;
      press_q      <= press_d;
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      valid_q      <= valid_d;
    end
  end

  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign operands_valid = valid_q;
  assign state          = state_q;
  assign press_pulse    = press_q;

endmodule
